// File: rtl/alu_multiciclo.sv
// alu_multiciclo: registered ALU with valid/ready handshakes, NZCV flags and a bit-serial shifter
module alu_multiciclo #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  input  logic [3:0]       ALUControl,
  input  logic             ALUFlagIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ANCHO-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);
  localparam int CW = $clog2(ANCHO + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [ANCHO-1:0] work, sel, x, y, yy, r, sh_w;
  logic [ANCHO:0] sum;
  logic [CW-1:0] cnt, amt;
  logic [3:0] f;
  logic fill, left, sh_c, accept, is_shift, is_arith, is_sub, unary;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign is_shift = ALUControl == 4'd8 || ALUControl == 4'd9;
  assign amt = (B >= ANCHO'(ANCHO)) ? CW'(ANCHO) : CW'(B);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = (is_shift && amt != '0) ? SHIFT : DONE;
    else if (state == SHIFT && cnt == CW'(1)) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  // Subtraction is x + ~y + 1, so the adder carry-out is directly the no-borrow flag
  always_comb begin
    sel = ALUFlagIn ? B : A;
    unary = ALUControl == 4'd3 || ALUControl == 4'd4;
    is_sub = ALUControl == 4'd4 || ALUControl == 4'd6;
    is_arith = unary || ALUControl == 4'd2 || ALUControl == 4'd6;
    x = unary ? sel : A;
    y = unary ? ANCHO'(1) : B;
    yy = is_sub ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {{ANCHO{1'b0}}, is_sub};
    r = ALUControl == 4'd0 ? A & B :
        ALUControl == 4'd1 ? A | B :
        ALUControl == 4'd5 ? ~sel :
        ALUControl == 4'd7 ? A ^ B :
        is_arith ? sum[ANCHO-1:0] :
        is_shift ? A : '0;
    f = {r[ANCHO-1], r == '0, is_arith & sum[ANCHO],
         is_arith & (x[ANCHO-1] == yy[ANCHO-1]) & (r[ANCHO-1] != x[ANCHO-1])};
    sh_w = left ? {work[ANCHO-2:0], fill} : {fill, work[ANCHO-1:1]};
    sh_c = left ? work[ANCHO-1] : work[0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      work <= '0;
      cnt <= '0;
      fill <= 1'b0;
      left <= 1'b0;
      ALUResult <= '0;
      ALUFlags <= '0;
    end else if (accept) begin
      work <= A;
      cnt <= amt;
      fill <= ALUFlagIn;
      left <= ALUControl == 4'd8;
      ALUResult <= r;
      ALUFlags <= f;
    end else if (state == SHIFT) begin
      work <= sh_w;
      cnt <= cnt - CW'(1);
      ALUResult <= sh_w;
      ALUFlags <= {sh_w[ANCHO-1], sh_w == '0, sh_c, 1'b0};
    end
endmodule
